mig_word_bridge: RTL

- Parametrised bridge between the core's single-word memory request port and the DDR3 controller application interface (app_*), on the controller's user clock.
- Maps word-granular byte addresses onto full-width app beats.
- Writes use byte masks instead of overwriting the whole beat. Reads extract the addressed lane.
- Adds a valid/ready request handshake, independent command/data acceptance on writes, and a read timeout with error reporting.

---
 rtl/mig_word_bridge.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mig_word_bridge.sv
// mig_word_bridge
//   Bridges a single-word core request port onto the DDR3 controller app_*
//   interface. Each request is one full-width app beat: writes replicate the
//   word across all lanes and mask off every byte except the addressed lane;
//   reads return the addressed lane of the returned beat.
//
// Ports
//   clk, reset_n             controller user clock, async active-low reset
//   req_valid/ready/write    core request handshake and direction
//   req_addr, req_wdata      core byte address and write word
//   resp_valid/err/rdata     one-cycle completion pulse, timeout flag, read word
//   init_calib_complete      controller calibration done
//   app_addr/cmd/en/rdy      controller command channel
//   app_wdf_data/mask/wren/end/rdy  controller write-data channel
//   app_rd_data/_valid       controller read-data channel
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_INIT    | waiting for controller calibration
// ST_IDLE    | ready for a core request
// ST_WR      | write command and write data outstanding (accepted independently)
// ST_RD_CMD  | read command presented, waiting for app_rdy
// ST_RD_WAIT | read accepted, waiting for data or the timeout terminal count
// ST_RESP    | one-cycle response to the core

module mig_word_bridge #(
  parameter int WORD_W      = 32,
  parameter int APP_DATA_W  = 128,
  parameter int REQ_ADDR_W  = 32,
  parameter int APP_ADDR_W  = 28,
  parameter int DQ_BYTES    = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [REQ_ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]       req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [WORD_W-1:0]       resp_rdata,
  input  logic                    init_calib_complete,
  output logic [APP_ADDR_W-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [APP_DATA_W-1:0]   app_wdf_data,
  output logic [APP_DATA_W/8-1:0] app_wdf_mask,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy,
  input  logic [APP_DATA_W-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid
);

  localparam int WORD_BYTES = WORD_W / 8;
  localparam int WB_LOG     = $clog2(WORD_BYTES);
  localparam int BB_LOG     = $clog2(APP_DATA_W / 8);
  localparam int LANES      = APP_DATA_W / WORD_W;
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TMR_W      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [APP_ADDR_W-1:0]   app_addr_q, app_addr_d;
  logic [2:0]              app_cmd_q, app_cmd_d;
  logic                    app_en_q, app_en_d;
  logic [APP_DATA_W-1:0]   app_wdf_data_q, app_wdf_data_d;
  logic [APP_DATA_W/8-1:0] app_wdf_mask_q, app_wdf_mask_d;
  logic                    app_wdf_wren_q, app_wdf_wren_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic [WORD_W-1:0]       resp_rdata_q, resp_rdata_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    drop_pending_q, drop_pending_d;
  logic [TMR_W-1:0]        timer_q, timer_d;

  logic [REQ_ADDR_W-1:0]   beat_base;
  logic [APP_ADDR_W-1:0]   app_addr_in;
  logic [LANE_W-1:0]       lane_in;
  logic [APP_DATA_W/8-1:0] wr_mask;
  logic [WORD_W-1:0]       rd_word;
  logic                    cmd_done;
  logic                    data_done;

  assign req_ready = (state_q == ST_IDLE);

  // Request address decode: beat-aligned byte address scaled to DQ units,
  // plus the word lane inside the beat.
  always_comb begin
    beat_base   = req_addr & ~REQ_ADDR_W'((1 << BB_LOG) - 1);
    app_addr_in = APP_ADDR_W'(beat_base / REQ_ADDR_W'(DQ_BYTES));
    lane_in     = (LANES > 1) ? LANE_W'(req_addr >> WB_LOG) : '0;
    wr_mask     = '1;
    wr_mask[int'(lane_in)*WORD_BYTES +: WORD_BYTES] = '0;
    rd_word     = app_rd_data[int'(lane_q)*WORD_W +: WORD_W];
  end

  // A channel counts as done once it was accepted earlier (strobe already low)
  // or is being accepted this cycle.
  assign cmd_done  = !app_en_q       || app_rdy;
  assign data_done = !app_wdf_wren_q || app_wdf_rdy;

  always_comb begin
    state_d        = state_q;
    app_addr_d     = app_addr_q;
    app_cmd_d      = app_cmd_q;
    app_en_d       = app_en_q;
    app_wdf_data_d = app_wdf_data_q;
    app_wdf_mask_d = app_wdf_mask_q;
    app_wdf_wren_d = app_wdf_wren_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = resp_err_q;
    resp_rdata_d   = resp_rdata_q;
    lane_d         = lane_q;
    drop_pending_d = drop_pending_q;
    timer_d        = timer_q;

    // The beat belonging to a timed-out read may turn up at any time later;
    // the first beat seen while the flag is set is swallowed.
    if (app_rd_data_valid && drop_pending_q) begin
      drop_pending_d = 1'b0;
    end

    unique case (state_q)
      ST_INIT: begin
        if (init_calib_complete) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (req_valid) begin
          app_addr_d = app_addr_in;
          lane_d     = lane_in;
          app_en_d   = 1'b1;
          if (req_write) begin
            app_cmd_d      = CMD_WR;
            app_wdf_wren_d = 1'b1;
            app_wdf_data_d = {LANES{req_wdata}};
            app_wdf_mask_d = wr_mask;
            state_d        = ST_WR;
          end else begin
            app_cmd_d = CMD_RD;
            state_d   = ST_RD_CMD;
          end
        end
      end

      ST_WR: begin
        if (app_en_q && app_rdy) begin
          app_en_d = 1'b0;
        end
        if (app_wdf_wren_q && app_wdf_rdy) begin
          app_wdf_wren_d = 1'b0;
        end
        if (cmd_done && data_done) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          state_d      = ST_RESP;
        end
      end

      ST_RD_CMD: begin
        if (app_rdy) begin
          app_en_d = 1'b0;
          timer_d  = TMR_W'(TIMEOUT_CYC);
          state_d  = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (app_rd_data_valid && !drop_pending_q) begin
          resp_rdata_d = rd_word;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else if (timer_q == '0) begin
          resp_rdata_d   = '0;
          resp_err_d     = 1'b1;
          resp_valid_d   = 1'b1;
          drop_pending_d = 1'b1;
          state_d        = ST_RESP;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_INIT;
      app_addr_q     <= '0;
      app_cmd_q      <= '0;
      app_en_q       <= 1'b0;
      app_wdf_data_q <= '0;
      app_wdf_mask_q <= '0;
      app_wdf_wren_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      lane_q         <= '0;
      drop_pending_q <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      app_addr_q     <= app_addr_d;
      app_cmd_q      <= app_cmd_d;
      app_en_q       <= app_en_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_wdf_mask_q <= app_wdf_mask_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
      lane_q         <= lane_d;
      drop_pending_q <= drop_pending_d;
      timer_q        <= timer_d;
    end
  end

  assign app_addr     = app_addr_q;
  assign app_cmd      = app_cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = app_wdf_data_q;
  assign app_wdf_mask = app_wdf_mask_q;
  assign app_wdf_wren = app_wdf_wren_q;
  assign app_wdf_end  = app_wdf_wren_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;

endmodule
